// File: rtl/binary_op_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : binary_op_pipe_pkg
//  Description : Shared opcode encodings and small helpers for the elastic
//                pipelined binary operator.
//  Revision    : 1.0 - initial release
// ============================================================================
package binary_op_pipe_pkg;

    // Opcode encodings; ADD=0 and REG=1 keep compatibility with the
    // existing add_op / reg_op numbering of the combinational operator.
    localparam int OP_ADD = 0;
    localparam int OP_REG = 1;
    localparam int OP_SUB = 2;
    localparam int OP_MUL = 3;
    localparam int OP_AND = 4;
    localparam int OP_OR  = 5;
    localparam int OP_XOR = 6;
    localparam int OP_MAX = OP_XOR;

    // True when the opcode is one the datapath implements.
    function automatic bit op_is_supported(input int op);
        return (op >= OP_ADD) && (op <= OP_MAX);
    endfunction

    // REG passes A straight through; every other opcode joins both streams.
    function automatic bit op_uses_b(input int op);
        return op != OP_REG;
    endfunction

endpackage : binary_op_pipe_pkg
`default_nettype wire

// File: rtl/binary_op_pipe_slice.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slice
//  Description : One elastic valid/ready register slice. Accepts a new token
//                whenever it is empty or its own token leaves this cycle, so
//                a full chain sustains one token per clock and compacts
//                bubbles while the far end is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_slice
    import binary_op_pipe_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    // upstream side
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    // downstream side
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Room for a new token if empty, or if the held token is taken now.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Load the slice on ready; payload only moves with a real token so a
    // bubble passing through leaves the previous data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule : pipe_slice
`default_nettype wire

// File: rtl/binary_op_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : binary_op_pipe
//  Description : Elastic pipelined binary operator. Joins the A and B
//                valid/ready streams, evaluates a parameter-selected ALU op
//                at the pipe input and carries {flag, result} through DEPTH
//                elastic register slices with full backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_op_pipe
    import binary_op_pipe_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int OP    = 0,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    // operand A stream
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    // operand B stream
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    // result stream
    output logic [WIDTH-1:0] y_data,
    output logic             y_flag,
    output logic             y_valid,
    input  logic             y_ready,
    // status
    output logic             busy
);

    localparam int SLICE_W = WIDTH + 1;
    localparam bit USES_B  = op_uses_b(OP);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (!op_is_supported(OP)) begin : g_bad_op
        $error("binary_op_pipe: unsupported OP %0d", OP);
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("binary_op_pipe: WIDTH must be >= 1, got %0d", WIDTH);
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("binary_op_pipe: DEPTH must be >= 1, got %0d", DEPTH);
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH:0]         w_sum;
    logic [WIDTH-1:0]       w_diff;
    logic                   w_borrow;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_res;
    logic                   w_flag;
    logic [SLICE_W-1:0]     w_alu;

    assign w_sum    = {1'b0, a_data} + {1'b0, b_data};
    assign w_diff   = a_data - b_data;
    assign w_borrow = (a_data < b_data);
    assign w_prod   = {{WIDTH{1'b0}}, a_data} * {{WIDTH{1'b0}}, b_data};

    // Select the result and its status flag for the configured opcode.
    always_comb begin
        w_res  = '0;
        w_flag = 1'b0;
        case (OP)
            OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_flag = w_sum[WIDTH];
            end
            OP_REG: begin
                w_res  = a_data;
            end
            OP_SUB: begin
                w_res  = w_diff;
                w_flag = w_borrow;
            end
            OP_MUL: begin
                w_res  = w_prod[WIDTH-1:0];
                w_flag = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_AND: w_res = a_data & b_data;
            OP_OR:  w_res = a_data | b_data;
            OP_XOR: w_res = a_data ^ b_data;
            default: begin
                w_res  = '0;
                w_flag = 1'b0;
            end
        endcase
    end

    assign w_alu = {w_flag, w_res};

    // ------------------------------------------------------------------
    // Join: both operands are taken together or not at all. REG ignores
    // the B stream entirely and never acknowledges it.
    // ------------------------------------------------------------------
    logic w_s0_ready;
    logic w_fire;
    logic w_unused;

    assign w_fire  = a_valid && (b_valid || !USES_B) && w_s0_ready;
    assign a_ready = w_fire;
    assign b_ready = USES_B ? w_fire : 1'b0;

    // B-side inputs are intentionally unread when OP is REG.
    assign w_unused = ^{b_valid, b_data};

    // ------------------------------------------------------------------
    // Slice chain. Each slice keeps its own link signals so the ready
    // path ripples from the output back to stage 0 without the chain
    // looking like one self-dependent vector.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]   w_slice_vld;
    logic               w_last_vld;
    logic [SLICE_W-1:0] w_last_dat;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        logic               w_in_vld;
        logic [SLICE_W-1:0] w_in_dat;
        logic               w_in_rdy;
        logic               w_out_vld;
        logic [SLICE_W-1:0] w_out_dat;
        logic               w_out_rdy;

        if (k == 0) begin : g_head
            assign w_in_vld   = w_fire;
            assign w_in_dat   = w_alu;
            assign w_s0_ready = w_in_rdy;
        end else begin : g_link
            assign w_in_vld = g_slice[k-1].w_out_vld;
            assign w_in_dat = g_slice[k-1].w_out_dat;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign w_out_rdy  = y_ready;
            assign w_last_vld = w_out_vld;
            assign w_last_dat = w_out_dat;
        end else begin : g_next
            assign w_out_rdy = g_slice[k+1].w_in_rdy;
        end

        assign w_slice_vld[k] = w_out_vld;

        pipe_slice #(
            .WIDTH (SLICE_W)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_in_vld),
            .i_data  (w_in_dat),
            .o_ready (w_in_rdy),
            .o_valid (w_out_vld),
            .o_data  (w_out_dat),
            .i_ready (w_out_rdy)
        );
    end

    // Outputs come straight from the last slice's registers.
    assign y_valid = w_last_vld;
    assign y_data  = w_last_dat[WIDTH-1:0];
    assign y_flag  = w_last_dat[WIDTH];
    assign busy    = |w_slice_vld;

endmodule : binary_op_pipe
`default_nettype wire

// File: tb/tb_binary_op_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_binary_op_pipe
//  Description : Self-checking bench for binary_op_pipe. A main ADD pipe
//                (WIDTH 8, DEPTH 3), a latency ADD pipe (WIDTH 8, DEPTH 2)
//                and one WIDTH 4 / DEPTH 2 pipe per opcode, all checked
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_op_pipe;
    import binary_op_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // main pipe: ADD, WIDTH 8, DEPTH 3
    logic [7:0] m_a, m_b, m_y;
    logic       m_av, m_bv, m_ar, m_br, m_yf, m_yv, m_yr, m_busy;
    // latency pipe: ADD, WIDTH 8, DEPTH 2
    logic [7:0] l_a, l_b, l_y;
    logic       l_av, l_bv, l_ar, l_br, l_yf, l_yv, l_yr, l_busy;
    // per-opcode pipes: WIDTH 4, DEPTH 2, shared stimulus
    logic [3:0]       o_a, o_b;
    logic             o_av, o_bv, o_yr;
    logic [6:0][3:0]  o_y;
    logic [6:0]       o_yf, o_yv, o_ar, o_br, o_busy;

    binary_op_pipe #(.WIDTH(8), .OP(OP_ADD), .DEPTH(3)) u_main (
        .clk(clk), .rst(rst),
        .a_data(m_a), .a_valid(m_av), .a_ready(m_ar),
        .b_data(m_b), .b_valid(m_bv), .b_ready(m_br),
        .y_data(m_y), .y_flag(m_yf), .y_valid(m_yv), .y_ready(m_yr),
        .busy(m_busy)
    );

    binary_op_pipe #(.WIDTH(8), .OP(OP_ADD), .DEPTH(2)) u_lat (
        .clk(clk), .rst(rst),
        .a_data(l_a), .a_valid(l_av), .a_ready(l_ar),
        .b_data(l_b), .b_valid(l_bv), .b_ready(l_br),
        .y_data(l_y), .y_flag(l_yf), .y_valid(l_yv), .y_ready(l_yr),
        .busy(l_busy)
    );

    for (genvar g = 0; g <= OP_MAX; g++) begin : g_ops
        binary_op_pipe #(.WIDTH(4), .OP(g), .DEPTH(2)) u_dut (
            .clk(clk), .rst(rst),
            .a_data(o_a), .a_valid(o_av), .a_ready(o_ar[g]),
            .b_data(o_b), .b_valid(o_bv), .b_ready(o_br[g]),
            .y_data(o_y[g]), .y_flag(o_yf[g]), .y_valid(o_yv[g]), .y_ready(o_yr),
            .busy(o_busy[g])
        );
    end

    // Reference: {flag, result} from plain integer arithmetic.
    function automatic logic [8:0] model(input int op, input int w, input int a, input int b);
        int m;
        int r;
        bit f;
        m = 1 << w;
        r = 0;
        f = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; f = (r >= m); r = r % m; end
            OP_REG: r = a;
            OP_SUB: begin f = (a < b); r = (a - b + m) % m; end
            OP_MUL: begin r = a * b; f = (r >= m); r = r % m; end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = 0;
        endcase
        return {f, 8'(r)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        checks++;
        if (m_yv !== 1'b0 || m_y !== 8'd0 || m_yf !== 1'b0 || m_busy !== 1'b0 ||
            l_yv !== 1'b0 || l_y !== 8'd0 || l_yf !== 1'b0 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_add: m_yv=%b m_y=%0d m_yf=%b m_busy=%b l_yv=%b l_y=%0d l_yf=%b l_busy=%b, all should be 0",
                     m_yv, m_y, m_yf, m_busy, l_yv, l_y, l_yf, l_busy);
        end
        checks++;
        if (o_yv !== 7'd0 || o_y !== '0 || o_yf !== 7'd0 || o_busy !== 7'd0) begin
            errors++;
            $display("FAIL reset_state_ops: yv=%b y=%h yf=%b busy=%b, all should be 0",
                     o_yv, o_y, o_yf, o_busy);
        end
    endtask

    task automatic test_reset();
        int seen;
        m_yr = 1'b1;
        m_a = 8'd1; m_b = 8'd2; m_av = 1'b1; m_bv = 1'b1;
        step();
        step();
        m_av = 1'b0; m_bv = 1'b0;
        step();
        checks++;
        if (m_yv !== 1'b1 || m_busy !== 1'b1 || m_y !== 8'd3) begin
            errors++;
            $display("FAIL reset_pre: yv=%b busy=%b y=%0d, expected yv=1 busy=1 y=3", m_yv, m_busy, m_y);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (m_yv !== 1'b0 || m_busy !== 1'b0 || m_y !== 8'd0 || m_yf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: yv=%b busy=%b y=%0d yf=%b, expected all 0", m_yv, m_busy, m_y, m_yf);
        end
        step();
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_yv === 1'b1) seen++;
        end
        step();
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_stale: %0d tokens after reset, expected 0", seen);
        end
    endtask

    task automatic test_add_latency();
        l_yr = 1'b1;
        l_a = 8'd200; l_b = 8'd100; l_av = 1'b1; l_bv = 1'b1;
        @(negedge clk);
        checks++;
        if (l_ar !== 1'b1 || l_br !== 1'b1) begin
            errors++;
            $display("FAIL lat_fire: a_ready=%b b_ready=%b, expected 1 1", l_ar, l_br);
        end
        step();
        l_av = 1'b0; l_bv = 1'b0;
        @(negedge clk);
        checks++;
        if (l_yv !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: y_valid=%b one cycle after fire, expected 0", l_yv);
        end
        step();
        @(negedge clk);
        checks++;
        if (l_yv !== 1'b1 || l_y !== 8'd44 || l_yf !== 1'b1) begin
            errors++;
            $display("FAIL lat_add: yv=%b y=%0d yf=%b, expected yv=1 y=44 yf=1", l_yv, l_y, l_yf);
        end
        step();
        @(negedge clk);
        checks++;
        if (l_yv !== 1'b0 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL lat_drain: yv=%b busy=%b, expected 0 0", l_yv, l_busy);
        end
        step();
    endtask

    task automatic test_join();
        int bad;
        int seen;
        logic [8:0] got;
        logic [8:0] exp;
        m_yr = 1'b1;
        m_a = 8'd7; m_b = 8'd9; m_av = 1'b1; m_bv = 1'b0;
        bad = 0; seen = 0; got = '0;
        repeat (5) begin
            @(negedge clk);
            if (m_ar !== 1'b0 || m_br !== 1'b0) bad++;
            if (m_yv === 1'b1) seen++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL join_hold: ready high in %0d of 5 cycles with B absent, expected 0", bad);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL join_no_token: %0d results with B absent, expected 0", seen);
        end
        m_bv = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ar !== 1'b1 || m_br !== 1'b1) begin
            errors++;
            $display("FAIL join_fire: a_ready=%b b_ready=%b, expected 1 1", m_ar, m_br);
        end
        step();
        m_av = 1'b0; m_bv = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_yv === 1'b1) begin
                seen++;
                got = {m_yf, m_y};
            end
        end
        step();
        exp = model(OP_ADD, 8, 7, 9);
        checks++;
        if (seen != 1 || got !== exp) begin
            errors++;
            $display("FAIL join_single: %0d results value %0d, expected 1 result value %0d", seen, got, exp);
        end
    endtask

    task automatic test_backpressure();
        int ta [10];
        int tb [10];
        logic [8:0] q [$];
        logic [8:0] e;
        int sent, recv, extra, unstable;
        bit prev_stall;
        logic [8:0] held;
        for (int i = 0; i < 10; i++) begin
            ta[i] = int'($urandom_range(0, 255));
            tb[i] = int'($urandom_range(0, 255));
        end
        sent = 0; recv = 0; extra = 0; unstable = 0;
        prev_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
            m_yr = (cyc >= 6);
            if (sent < 10) begin
                m_a = 8'(ta[sent]); m_b = 8'(tb[sent]); m_av = 1'b1; m_bv = 1'b1;
            end else begin
                m_av = 1'b0; m_bv = 1'b0;
            end
            @(negedge clk);
            if (cyc == 5) begin
                checks++;
                if (sent != 3 || m_ar !== 1'b0 || m_br !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_fill: accepted=%0d a_ready=%b b_ready=%b, expected 3 0 0", sent, m_ar, m_br);
                end
            end
            if (prev_stall && (m_yv !== 1'b1 || {m_yf, m_y} !== held)) unstable++;
            prev_stall = (m_yv === 1'b1) && (m_yr === 1'b0);
            held = {m_yf, m_y};
            if (m_av && m_ar === 1'b1) begin
                q.push_back(model(OP_ADD, 8, ta[sent], tb[sent]));
                sent++;
            end
            if (m_yv === 1'b1 && m_yr) begin
                if (q.size() == 0) begin
                    extra++;
                end else begin
                    e = q.pop_front();
                    checks++;
                    if ({m_yf, m_y} !== e) begin
                        errors++;
                        $display("FAIL bp_token%0d: got %0d, expected %0d", recv, {m_yf, m_y}, e);
                    end
                end
                recv++;
            end
            step();
        end
        m_av = 1'b0; m_bv = 1'b0;
        checks++;
        if (recv != 10 || extra != 0 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: received=%0d extra=%0d pending=%0d, expected 10 0 0", recv, extra, q.size());
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bp_stable: output changed in %0d stalled cycles, expected 0", unstable);
        end
    endtask

    task automatic test_throughput();
        int va [100];
        int vb [100];
        int stalls;
        logic [8:0] e;
        for (int i = 0; i < 100; i++) begin
            va[i] = int'($urandom_range(0, 255));
            vb[i] = int'($urandom_range(0, 255));
        end
        stalls = 0;
        m_yr = 1'b1;
        for (int cyc = 0; cyc < 103; cyc++) begin
            if (cyc < 100) begin
                m_a = 8'(va[cyc]); m_b = 8'(vb[cyc]); m_av = 1'b1; m_bv = 1'b1;
            end else begin
                m_av = 1'b0; m_bv = 1'b0;
            end
            @(negedge clk);
            if (cyc < 100 && m_ar !== 1'b1) stalls++;
            if (cyc >= 3) begin
                e = model(OP_ADD, 8, va[cyc-3], vb[cyc-3]);
                checks++;
                if (m_yv !== 1'b1 || {m_yf, m_y} !== e) begin
                    errors++;
                    $display("FAIL tp_vec%0d: yv=%b value=%0d, expected yv=1 value=%0d", cyc - 3, m_yv, {m_yf, m_y}, e);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (stalls != 0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL tp_rate: stalls=%0d busy_after=%b, expected 0 0", stalls, m_busy);
        end
        step();
    endtask

    task automatic test_ops();
        int va [42];
        int vb [42];
        int stalls, brbad, idx;
        logic [8:0] e;
        va[0] = 15; vb[0] = 15;
        va[1] = 3;  vb[1] = 5;
        for (int i = 2; i < 42; i++) begin
            va[i] = int'($urandom_range(0, 15));
            vb[i] = int'($urandom_range(0, 15));
        end
        stalls = 0; brbad = 0;
        o_yr = 1'b1;
        for (int cyc = 0; cyc < 44; cyc++) begin
            if (cyc < 42) begin
                o_a = 4'(va[cyc]); o_b = 4'(vb[cyc]); o_av = 1'b1; o_bv = 1'b1;
            end else begin
                o_av = 1'b0; o_bv = 1'b0;
            end
            @(negedge clk);
            if (cyc < 42) begin
                if (o_ar !== 7'h7f) stalls++;
                if (o_br !== 7'b1111101) brbad++;
            end
            if (cyc >= 2) begin
                idx = cyc - 2;
                if (idx == 0) begin
                    checks++;
                    if (o_y[OP_MUL] !== 4'd1 || o_yf[OP_MUL] !== 1'b1) begin
                        errors++;
                        $display("FAIL mul_15x15: y=%0d flag=%b, expected y=1 flag=1", o_y[OP_MUL], o_yf[OP_MUL]);
                    end
                end
                if (idx == 1) begin
                    checks++;
                    if (o_y[OP_SUB] !== 4'd14 || o_yf[OP_SUB] !== 1'b1) begin
                        errors++;
                        $display("FAIL sub_3m5: y=%0d flag=%b, expected y=14 flag=1", o_y[OP_SUB], o_yf[OP_SUB]);
                    end
                end
                for (int op = 0; op <= OP_MAX; op++) begin
                    e = model(op, 4, va[idx], vb[idx]);
                    checks++;
                    if (o_yv[op] !== 1'b1 || o_y[op] !== e[3:0] || o_yf[op] !== e[8]) begin
                        errors++;
                        $display("FAIL op%0d_vec%0d: yv=%b y=%0d flag=%b, expected yv=1 y=%0d flag=%b",
                                 op, idx, o_yv[op], o_y[op], o_yf[op], e[3:0], e[8]);
                    end
                end
            end
            step();
        end
        checks++;
        if (stalls != 0 || brbad != 0) begin
            errors++;
            $display("FAIL ops_ready: a_ready bad in %0d cycles, b_ready bad in %0d cycles, expected 0 0", stalls, brbad);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_a = '0; m_b = '0; m_av = 1'b0; m_bv = 1'b0; m_yr = 1'b0;
        l_a = '0; l_b = '0; l_av = 1'b0; l_bv = 1'b0; l_yr = 1'b0;
        o_a = '0; o_b = '0; o_av = 1'b0; o_bv = 1'b0; o_yr = 1'b0;
        repeat (3) step();
        test_reset_state();
        rst = 1'b0;
        step();
        test_reset();
        test_add_latency();
        test_join();
        test_backpressure();
        test_throughput();
        test_ops();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_binary_op_pipe
`default_nettype wire
